// File: rtl/sram_fetch_pipeline.sv
// sram_fetch_pipeline: per-pixel SRAM word fetch with same-word read suppression.
// Stage 0 computes and registers the SRAM word address and read strobe. The pixel
// metadata then passes through an SRAM_LAT-deep delay line, so that it reaches the
// tap in the same cycle as the returned word. The tap extracts the colour field,
// and a final register presents the result.
// Optional feature macro: SRAM_FETCH_STATS_EN (per-frame read / reuse counters).
module sram_fetch_pipeline #(
  parameter int NUM_OBJ  = 8,
  parameter int ID_W     = 4,
  parameter int IDX_W    = 20,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int COLOR_W  = 4,
  parameter int SRAM_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_start,
  input  logic                      i_valid,
  input  logic [ID_W-1:0]           i_object_id,
  input  logic [IDX_W-1:0]          i_pixel_index,
  input  logic [NUM_OBJ*ADDR_W-1:0] i_base_addr,
  output logic [ADDR_W-1:0]         o_sram_addr,
  output logic                      o_sram_rd,
  input  logic [DATA_W-1:0]         i_sram_data,
  output logic                      o_valid,
  output logic [ID_W-1:0]           o_object_id,
  output logic [COLOR_W-1:0]        o_color,
  output logic                      o_bad_id,
  output logic [23:0]               o_stat_reads,
  output logic [23:0]               o_stat_reuse
);

  localparam int PPW     = DATA_W / COLOR_W;
  localparam int LOG_PPW = $clog2(PPW);
  localparam int SUB_W   = (LOG_PPW > 0) ? LOG_PPW : 1;

  typedef struct packed {
    logic             valid;
    logic             rd;
    logic             bad;
    logic [ID_W-1:0]  id;
    logic [SUB_W-1:0] sub;
  } meta_t;

  // Index 0 is the issue register; indices 1..SRAM_LAT form the delay line.
  meta_t meta_q [0:SRAM_LAT];
  meta_t meta_d [0:SRAM_LAT];

  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic               sram_rd_q, sram_rd_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic               last_valid_q, last_valid_d;
  logic [DATA_W-1:0]  hold_word_q, hold_word_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               bad_q, bad_d;

  logic               bad_s;
  logic [ID_W-1:0]    sel_id_s;
  logic [ADDR_W-1:0]  base_sel_s;
  logic [ADDR_W-1:0]  word_addr_s;
  logic [SUB_W-1:0]   sub_s;
  logic               last_valid_eff_s;
  logic               reuse_s;
  logic               read_s;
  logic [DATA_W-1:0]  word_s;
  meta_t              tap_s;

  // Issue stage: address generation, same-word compare and read decision.
  always_comb begin
    bad_s            = (32'(i_object_id) >= 32'(NUM_OBJ));
    sel_id_s         = bad_s ? '0 : i_object_id;
    base_sel_s       = i_base_addr[int'(sel_id_s)*ADDR_W +: ADDR_W];
    word_addr_s      = bad_s ? '0 : (base_sel_s + ADDR_W'(i_pixel_index >> LOG_PPW));
    sub_s            = SUB_W'(i_pixel_index & IDX_W'(PPW - 1));
    // A frame start forgets the previous word so the first pixel always reads.
    last_valid_eff_s = i_frame_start ? 1'b0 : last_valid_q;
    reuse_s          = i_valid & ~bad_s & last_valid_eff_s & (word_addr_s == last_addr_q);
    read_s           = i_valid & ~bad_s & ~reuse_s;
    sram_rd_d        = read_s;
    sram_addr_d      = read_s ? word_addr_s : sram_addr_q;
    last_addr_d      = read_s ? word_addr_s : last_addr_q;
    last_valid_d     = read_s ? 1'b1 : last_valid_eff_s;
    meta_d[0]        = '0;
    if (i_valid) begin
      meta_d[0].valid = 1'b1;
      meta_d[0].rd    = read_s;
      meta_d[0].bad   = bad_s;
      meta_d[0].id    = i_object_id;
      meta_d[0].sub   = sub_s;
    end else begin
      meta_d[0] = '0;
    end
    for (int k = 1; k <= SRAM_LAT; k++) begin
      meta_d[k] = meta_q[k-1];
    end
  end

  // Tap and output stage: select the fresh or held word and extract the colour.
  always_comb begin
    tap_s       = meta_q[SRAM_LAT];
    word_s      = tap_s.rd ? i_sram_data : hold_word_q;
    hold_word_d = word_s;
    valid_d     = tap_s.valid;
    id_d        = tap_s.valid ? tap_s.id : '0;
    bad_d       = tap_s.valid & tap_s.bad;
    if (tap_s.valid && !tap_s.bad) begin
      color_d = COLOR_W'(word_s >> (32'(tap_s.sub) * COLOR_W));
    end else begin
      color_d = '0;
    end
  end

  // State registers for issue, delay line, held word and output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sram_addr_q  <= '0;
      sram_rd_q    <= 1'b0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      hold_word_q  <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      color_q      <= '0;
      bad_q        <= 1'b0;
      for (int k = 0; k <= SRAM_LAT; k++) begin
        meta_q[k] <= '0;
      end
    end else begin
      sram_addr_q  <= sram_addr_d;
      sram_rd_q    <= sram_rd_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      hold_word_q  <= hold_word_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      color_q      <= color_d;
      bad_q        <= bad_d;
      for (int k = 0; k <= SRAM_LAT; k++) begin
        meta_q[k] <= meta_d[k];
      end
    end
  end

  assign o_sram_addr = sram_addr_q;
  assign o_sram_rd   = sram_rd_q;
  assign o_valid     = valid_q;
  assign o_object_id = id_q;
  assign o_color     = color_q;
  assign o_bad_id    = bad_q;

`ifdef SRAM_FETCH_STATS_EN
  logic [23:0] reads_cnt_q, reads_cnt_d;
  logic [23:0] reuse_cnt_q, reuse_cnt_d;
  logic [23:0] stat_reads_q, stat_reads_d;
  logic [23:0] stat_reuse_q, stat_reuse_d;
  logic [23:0] reads_base_s, reuse_base_s;

  // Saturating per-frame counters; a frame start snapshots and restarts them.
  always_comb begin
    reads_base_s = i_frame_start ? 24'd0 : reads_cnt_q;
    reuse_base_s = i_frame_start ? 24'd0 : reuse_cnt_q;
    if (read_s && (reads_base_s != 24'hFF_FFFF)) begin
      reads_cnt_d = reads_base_s + 24'd1;
    end else begin
      reads_cnt_d = reads_base_s;
    end
    if (reuse_s && (reuse_base_s != 24'hFF_FFFF)) begin
      reuse_cnt_d = reuse_base_s + 24'd1;
    end else begin
      reuse_cnt_d = reuse_base_s;
    end
    stat_reads_d = i_frame_start ? reads_cnt_q : stat_reads_q;
    stat_reuse_d = i_frame_start ? reuse_cnt_q : stat_reuse_q;
  end

  // Statistics registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reads_cnt_q  <= 24'd0;
      reuse_cnt_q  <= 24'd0;
      stat_reads_q <= 24'd0;
      stat_reuse_q <= 24'd0;
    end else begin
      reads_cnt_q  <= reads_cnt_d;
      reuse_cnt_q  <= reuse_cnt_d;
      stat_reads_q <= stat_reads_d;
      stat_reuse_q <= stat_reuse_d;
    end
  end

  assign o_stat_reads = stat_reads_q;
  assign o_stat_reuse = stat_reuse_q;
`else
  assign o_stat_reads = 24'd0;
  assign o_stat_reuse = 24'd0;
`endif

endmodule

// File: tb/tb_sram_fetch_pipeline.sv
// Randomised scoreboard bench for sram_fetch_pipeline with a behavioural SRAM.
module tb_sram_fetch_pipeline;

  localparam int NUM_OBJ  = 8;
  localparam int ID_W     = 4;
  localparam int IDX_W    = 20;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int COLOR_W  = 4;
  localparam int SRAM_LAT = 2;
  localparam int PPW      = DATA_W / COLOR_W;

  logic                      clk;
  logic                      i_rst;
  logic                      i_frame_start;
  logic                      i_valid;
  logic [ID_W-1:0]           i_object_id;
  logic [IDX_W-1:0]          i_pixel_index;
  logic [NUM_OBJ*ADDR_W-1:0] i_base_addr;
  logic [ADDR_W-1:0]         o_sram_addr;
  logic                      o_sram_rd;
  logic [DATA_W-1:0]         i_sram_data;
  logic                      o_valid;
  logic [ID_W-1:0]           o_object_id;
  logic [COLOR_W-1:0]        o_color;
  logic                      o_bad_id;
  logic [23:0]               o_stat_reads;
  logic [23:0]               o_stat_reuse;

  sram_fetch_pipeline #(
    .NUM_OBJ(NUM_OBJ), .ID_W(ID_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .COLOR_W(COLOR_W), .SRAM_LAT(SRAM_LAT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_object_id(i_object_id), .i_pixel_index(i_pixel_index), .i_base_addr(i_base_addr),
    .o_sram_addr(o_sram_addr), .o_sram_rd(o_sram_rd), .i_sram_data(i_sram_data),
    .o_valid(o_valid), .o_object_id(o_object_id), .o_color(o_color), .o_bad_id(o_bad_id),
    .o_stat_reads(o_stat_reads), .o_stat_reuse(o_stat_reuse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int neg_cnt = 0;

  typedef struct {
    int              due;
    logic [ID_W-1:0] id;
    logic [3:0]      color;
    logic            badid;
  } exp_t;
  exp_t sbq[$];

  // SRAM contents: a fixed hash, with word 0x100 pinned for the directed nibble test.
  function automatic logic [15:0] mem_word(input logic [19:0] a);
    logic [19:0] h;
    if (a == 20'h00100) return 16'hDCBA;
    h = (a * 20'h09E37) ^ (a >> 3);
    return h[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural SRAM: data appears SRAM_LAT cycles after the registered address;
  // cycles without a read return junk so held-word use is exercised.
  logic [ADDR_W-1:0] a_pipe [1:SRAM_LAT];
  logic              r_pipe [1:SRAM_LAT];
  logic [15:0]       junk;
  always @(posedge clk) begin
    a_pipe[1] <= o_sram_addr;
    r_pipe[1] <= o_sram_rd;
    for (int k = 2; k <= SRAM_LAT; k++) begin
      a_pipe[k] <= a_pipe[k-1];
      r_pipe[k] <= r_pipe[k-1];
    end
    junk <= 16'($urandom);
  end
  assign i_sram_data = r_pipe[SRAM_LAT] ? mem_word(a_pipe[SRAM_LAT]) : junk;

  // Reference state
  logic [ADDR_W-1:0] base_m [NUM_OBJ];
  bit                have_last;
  logic [ADDR_W-1:0] last_w;
  logic [ADDR_W-1:0] exp_addr;
  int                fr_reads, fr_reuse, st_reads, st_reuse;
  int                rd_seen;

  always_comb begin
    for (int k = 0; k < NUM_OBJ; k++) i_base_addr[k*ADDR_W +: ADDR_W] = base_m[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented pixel (or every due one) is compared with the queue head.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (o_valid || (sbq.size() > 0 && sbq[0].due == neg_cnt)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid actual=1 required=0 at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("o_valid", 32'(o_valid), 32'd1);
        chk("latency", neg_cnt, e.due);
        chk("o_object_id", 32'(o_object_id), 32'(e.id));
        chk("o_color", 32'(o_color), 32'(e.color));
        chk("o_bad_id", 32'(o_bad_id), 32'(e.badid));
      end
    end
  end

  // One request cycle: predict from the rules, apply, then check the issue outputs.
  task automatic issue(input logic v, input logic [ID_W-1:0] id,
                       input logic [IDX_W-1:0] idx, input logic fs);
    logic [ADDR_W-1:0] w;
    logic              bad_m, exp_rd;
    exp_t              e;
    i_valid = v; i_object_id = id; i_pixel_index = idx; i_frame_start = fs;
    bad_m = (int'(id) >= NUM_OBJ);
    w = bad_m ? 20'd0 : ADDR_W'(base_m[bad_m ? 0 : int'(id)] + idx / PPW);
    if (fs) begin
      st_reads = fr_reads; st_reuse = fr_reuse;
      fr_reads = 0; fr_reuse = 0;
      have_last = 1'b0;
    end
    exp_rd = 1'b0;
    if (v && !bad_m) begin
      if (have_last && w == last_w) begin
        fr_reuse++;
      end else begin
        exp_rd = 1'b1; last_w = w; have_last = 1'b1; exp_addr = w; fr_reads++;
      end
    end
    e.id = id;
    e.badid = bad_m;
    e.color = bad_m ? 4'd0 : 4'(mem_word(w) >> ((idx % PPW) * COLOR_W));
    @(posedge clk);
    #1;
    if (v) begin
      e.due = neg_cnt + SRAM_LAT + 2;
      sbq.push_back(e);
    end
    if (o_sram_rd) rd_seen++;
    chk("o_sram_rd", 32'(o_sram_rd), 32'(exp_rd));
    chk("o_sram_addr", 32'(o_sram_addr), 32'(exp_addr));
    if (fs) begin
`ifdef SRAM_FETCH_STATS_EN
      chk("o_stat_reads", 32'(o_stat_reads), st_reads);
      chk("o_stat_reuse", 32'(o_stat_reuse), st_reuse);
`else
      chk("o_stat_reads", 32'(o_stat_reads), 32'd0);
      chk("o_stat_reuse", 32'(o_stat_reuse), 32'd0);
`endif
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_frame_start = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    have_last = 1'b0; exp_addr = 20'd0;
    fr_reads = 0; fr_reuse = 0; st_reads = 0; st_reuse = 0;
    chk("o_valid_after_rst", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int cur_idx;
    logic [ID_W-1:0] rid;
    i_rst = 1'b1; i_valid = 1'b0; i_frame_start = 1'b0;
    i_object_id = '0; i_pixel_index = '0;
    for (int k = 0; k < NUM_OBJ; k++) base_m[k] = ADDR_W'($urandom);
    base_m[1] = 20'h00100;
    base_m[2] = 20'h00200;
    #2;
    do_reset();
    chk("rst_o_sram_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_o_sram_rd", 32'(o_sram_rd), 32'd0);
    chk("rst_o_color", 32'(o_color), 32'd0);
    chk("rst_o_bad_id", 32'(o_bad_id), 32'd0);
    chk("rst_o_object_id", 32'(o_object_id), 32'd0);
    chk("rst_o_stat_reads", 32'(o_stat_reads), 32'd0);

    // id 1, index 0..7: two reads, at 0x100 and 0x101
    rd_seen = 0;
    for (int i = 0; i < 8; i++) issue(1'b1, 4'd1, IDX_W'(i), 1'b0);
    chk("dir_read_count", rd_seen, 32'd2);
    // blanking gap then the same pixel: no re-read, held word used
    issue(1'b1, 4'd1, 20'd3, 1'b0);
    rd_seen = 0;
    for (int i = 0; i < 3; i++) issue(1'b0, 4'd0, 20'd0, 1'b0);
    issue(1'b1, 4'd1, 20'd3, 1'b0);
    chk("gap_no_reread", rd_seen, 32'd0);
    // out-of-range id followed by a normal one
    issue(1'b1, 4'd9, 20'd5, 1'b0);
    issue(1'b1, 4'd2, 20'd0, 1'b0);
    // frame start on a repeated address forces a read
    issue(1'b1, 4'd2, 20'd0, 1'b1);
    // a full frame of 8 pixels over 2 words, closed by the next pulse
    for (int i = 0; i < 8; i++) issue(1'b1, 4'd1, IDX_W'(i), i == 0);
    issue(1'b0, 4'd0, 20'd0, 1'b1);
    // reset with pixels in flight
    for (int i = 0; i < 3; i++) issue(1'b1, 4'd2, IDX_W'(i + 4), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) issue(1'b0, 4'd0, 20'd0, 1'b0);

    // random traffic
    cur_idx = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) base_m[$urandom_range(0, NUM_OBJ - 1)] = ADDR_W'($urandom);
      if ($urandom_range(0, 2) == 0) cur_idx = int'($urandom_range(0, 4095));
      else cur_idx = cur_idx + 1;
      rid = ($urandom_range(0, 9) == 0) ? ID_W'($urandom_range(8, 15)) : ID_W'($urandom_range(0, 2));
      if (n == 300) do_reset();
      issue($urandom_range(0, 3) != 0, rid, IDX_W'(cur_idx), $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < SRAM_LAT + 4; i++) issue(1'b0, 4'd0, 20'd0, 1'b0);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fetch_pipeline.md
Name: sram_fetch_pipeline

Overview:
- Generalised successor of the per-pixel SRAM fetch stage between the pixel decoder and the colour decoder.
- Accepts one pixel request per cycle (object id, pixel index, valid) and issues a registered SRAM word address.
- Carries the pixel metadata through a parametrised SRAM-latency delay line and extracts the packed colour field from the returned word.
- Suppresses redundant reads when consecutive valid pixels hit the same SRAM word; blanking pixels never move the address.

Parameters:
- NUM_OBJ, 8: number of object ids with a base-address entry.
- ID_W, 4: object id width.
- IDX_W, 20: object pixel index width.
- ADDR_W, 20: SRAM word address width.
- DATA_W, 16: SRAM data width.
- COLOR_W, 4: encoded colour width. DATA_W % COLOR_W == 0 is required. PPW = DATA_W/COLOR_W is derived and must be a power of two.
- SRAM_LAT, 2: cycles from o_sram_addr/o_sram_rd registered to i_sram_data valid. Legal range is 1..8.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_frame_start  in  1  one-cycle pulse at the first pixel of a frame
- i_valid  in  1  request valid; low during blanking
- i_object_id  in  ID_W  object id of the request
- i_pixel_index  in  IDX_W  pixel index within the object
- i_base_addr  in  NUM_OBJ*ADDR_W  flattened per-object base word address; entry k is at bits [k*ADDR_W +: ADDR_W]
- o_sram_addr  out  ADDR_W  registered SRAM word address
- o_sram_rd  out  1  registered read strobe
- i_sram_data  in  DATA_W  SRAM read data
- o_valid  out  1  output pixel valid
- o_object_id  out  ID_W  delayed object id
- o_color  out  COLOR_W  extracted encoded colour
- o_bad_id  out  1  id was >= NUM_OBJ
- o_stat_reads  out  24  reads issued in the previous frame (only meaningful with the optional feature)
- o_stat_reuse  out  24  reads suppressed in the previous frame (only meaningful with the optional feature)

Behaviour:
- Single clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; delay line cleared; last-address-valid flag cleared; held word 0.

Stage 0 (issue), on each cycle with i_valid=1:
- word_addr = base[id] + (pixel_index >> log2(PPW)), truncated to ADDR_W with modulo wrap.
- sub = pixel_index[log2(PPW)-1:0].
- If id >= NUM_OBJ: bad=1, word_addr=0, no read issued.
- Otherwise, if last_valid and word_addr == last_addr: reuse. o_sram_rd <= 0, o_sram_addr holds.
- Otherwise: o_sram_rd <= 1, o_sram_addr <= word_addr, last_addr <= word_addr, last_valid <= 1.

Stage 0, on each cycle with i_valid=0:
- o_sram_rd <= 0; o_sram_addr holds.
- last_valid is kept, so reuse across a blanking gap is allowed.

Delay line:
- SRAM_LAT registers carrying {valid, rd, bad, id, sub}.
- At the tap aligned with i_sram_data: if rd, then word = i_sram_data and hold_word <= i_sram_data; else word = hold_word.

Output register (one stage):
- o_valid, o_object_id, o_bad_id are taken from the tap.
- o_color = bad ? 0 : word[sub*COLOR_W +: COLOR_W].
- When o_valid=0, o_color and o_bad_id are 0.

Latency and ordering:
- Fixed latency i_valid -> o_valid is SRAM_LAT+2 cycles (1 issue + SRAM_LAT + 1 output).
- Throughput is one pixel per cycle, with no backpressure.
- Ordering is strictly in-order.

Boundary conditions:
- i_frame_start clears last_valid in the same cycle before the compare, so the first pixel of every frame always reads.
- Reset mid-stream flushes all in-flight pixels: no o_valid until new requests have traversed the full latency.
- i_base_addr may change at any time; it is sampled only at issue.

Optional Feature:
- Macro: SRAM_FETCH_STATS_EN.
- Defined: two 24-bit saturating counters count issued reads and suppressed reuses. On i_frame_start they are copied to o_stat_reads/o_stat_reuse and cleared. If the pulse cycle itself issues or reuses, that event counts in the new frame. Counters and outputs are cleared on reset.
- Undefined: o_stat_reads and o_stat_reuse are tied to 0 and no counters are synthesised.

Test Plan:
- Reset, then id=1, base[1]=0x100, index 0..7 consecutive, PPW=4 -> o_sram_rd pulses only for index 0 and 4, at addr 0x100 and 0x101. o_valid rises 4 cycles (SRAM_LAT=2) after the first i_valid. o_color follows nibbles of the returned words.
- Word 0x100 = 0xDCBA, indices 0..3 -> o_color = A, B, C, D in order.
- i_valid gap of 3 cycles between index 3 and index 3 again -> no re-read; o_color=D from the held word; o_sram_addr unchanged during the gap.
- id=9 (>= NUM_OBJ) -> o_sram_rd=0, o_bad_id=1, o_color=0 at latency 4. A following valid id=2 reads normally.
- i_frame_start on a repeat of the last address -> read reissued. With SRAM_FETCH_STATS_EN, a frame of 8 pixels over 2 words gives o_stat_reads=2 and o_stat_reuse=6 after the next pulse.
- Assert i_rst with 3 pixels in flight -> o_valid is 0 the following cycle and stays 0 until a new request completes the full latency.
